// File: rtl/softex_pkg.sv
// Shared types and default widths for the softex x-buffer scheduler.
package softex_pkg;

  localparam int unsigned BUF_CNT_WIDTH  = 8;
  localparam int unsigned BEAT_CNT_WIDTH = 16;
  localparam int unsigned ROW_CNT_WIDTH  = 16;

  typedef struct packed {
    logic [BUF_CNT_WIDTH-1:0] num_loops;
  } x_buffer_ctrl_t;

  typedef enum logic [1:0] {
    X_SCHED_IDLE,
    X_SCHED_RUN,
    X_SCHED_DONE
  } x_sched_state_t;

endpackage

// File: rtl/softex_x_buffer_sched.sv
// Replay scheduler for the softex x-buffer: loops/beats/rows counters and push-enable.
// Optional stall counter output enabled by defining SOFTEX_X_BUFFER_SCHED_PERF_EN.
module softex_x_buffer_sched
  import softex_pkg::*;
#(
  parameter int unsigned LOOP_W = BUF_CNT_WIDTH,
  parameter int unsigned BEAT_W = 16,
  parameter int unsigned ROW_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              start_i,
  input  logic [LOOP_W-1:0] num_loops_i,
  input  logic [BEAT_W-1:0] row_beats_i,
  input  logic [ROW_W-1:0]  num_rows_i,
  input  logic              in_hs_i,
  input  logic              out_hs_i,
  output x_buffer_ctrl_t    ctrl_o,
  output logic              in_en_o,
  output logic [LOOP_W-1:0] pass_o,
  output logic              last_pass_o,
  output logic              last_beat_o,
  output logic              last_row_o,
  output logic              busy_o,
`ifdef SOFTEX_X_BUFFER_SCHED_PERF_EN
  output logic [31:0]       stall_cnt_o,
`endif
  output logic              done_o
);

  localparam int unsigned IN_W = BEAT_W + ROW_W;

  x_sched_state_t    state_reg, state_next;
  logic [LOOP_W-1:0] loops_reg, loop_cnt_reg, loop_cnt_next;
  logic [BEAT_W-1:0] beats_reg, beat_cnt_reg, beat_cnt_next;
  logic [ROW_W-1:0]  rows_reg, row_cnt_reg, row_cnt_next;
  logic [IN_W-1:0]   in_cnt_reg, in_cnt_next, in_total;
  logic              cfg_load;
  logic              is_run, last_pass, last_beat, last_row;

  assign is_run    = (state_reg == X_SCHED_RUN);
  assign last_pass = (loop_cnt_reg == loops_reg - LOOP_W'(1));
  assign last_beat = (beat_cnt_reg == beats_reg - BEAT_W'(1));
  assign last_row  = (row_cnt_reg == rows_reg - ROW_W'(1));
  // Both operands widened first so the product can never truncate.
  assign in_total  = IN_W'(beats_reg) * IN_W'(rows_reg);

  always_comb begin
    state_next    = state_reg;
    loop_cnt_next = loop_cnt_reg;
    beat_cnt_next = beat_cnt_reg;
    row_cnt_next  = row_cnt_reg;
    in_cnt_next   = in_cnt_reg;
    cfg_load      = 1'b0;
    if (clear_i) begin
      state_next    = X_SCHED_IDLE;
      loop_cnt_next = '0;
      beat_cnt_next = '0;
      row_cnt_next  = '0;
      in_cnt_next   = '0;
    end else begin
      case (state_reg)
        X_SCHED_IDLE: begin
          if (start_i) begin
            cfg_load      = 1'b1;
            loop_cnt_next = '0;
            beat_cnt_next = '0;
            row_cnt_next  = '0;
            in_cnt_next   = '0;
            if (num_loops_i == '0 || row_beats_i == '0 || num_rows_i == '0)
              state_next = X_SCHED_DONE;
            else
              state_next = X_SCHED_RUN;
          end
        end
        X_SCHED_RUN: begin
          if (in_hs_i)
            in_cnt_next = in_cnt_reg + IN_W'(1);
          if (out_hs_i) begin
            if (last_pass) begin
              loop_cnt_next = '0;
              if (last_beat) begin
                beat_cnt_next = '0;
                row_cnt_next  = row_cnt_reg + ROW_W'(1);
                if (last_row)
                  state_next = X_SCHED_DONE;
              end else begin
                beat_cnt_next = beat_cnt_reg + BEAT_W'(1);
              end
            end else begin
              loop_cnt_next = loop_cnt_reg + LOOP_W'(1);
            end
          end
        end
        X_SCHED_DONE: state_next = X_SCHED_IDLE;
        default:      state_next = X_SCHED_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg    <= X_SCHED_IDLE;
      loop_cnt_reg <= '0;
      beat_cnt_reg <= '0;
      row_cnt_reg  <= '0;
      in_cnt_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      loop_cnt_reg <= loop_cnt_next;
      beat_cnt_reg <= beat_cnt_next;
      row_cnt_reg  <= row_cnt_next;
      in_cnt_reg   <= in_cnt_next;
    end
  end

  // Config survives a soft clear so ctrl_o holds until the next start.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      loops_reg <= '0;
      beats_reg <= '0;
      rows_reg  <= '0;
    end else if (cfg_load) begin
      loops_reg <= num_loops_i;
      beats_reg <= row_beats_i;
      rows_reg  <= num_rows_i;
    end
  end

  assign ctrl_o.num_loops = BUF_CNT_WIDTH'(loops_reg);
  assign in_en_o          = is_run && (in_cnt_reg < in_total);
  assign pass_o           = loop_cnt_reg;
  assign last_pass_o      = is_run && last_pass;
  assign last_beat_o      = is_run && last_beat;
  assign last_row_o       = is_run && last_row;
  assign busy_o           = is_run;
  assign done_o           = (state_reg == X_SCHED_DONE);

`ifdef SOFTEX_X_BUFFER_SCHED_PERF_EN
  logic [31:0] stall_cnt_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i || cfg_load)
      stall_cnt_reg <= '0;
    else if (is_run && !in_hs_i && !out_hs_i && stall_cnt_reg != '1)
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
  end

  assign stall_cnt_o = stall_cnt_reg;
`endif

endmodule
